// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder backing-store model.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_t;

  localparam int DEFAULT_LATENCY = 4;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'h5A;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic lfsr_feedback(input logic [7:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// 8-bit Fibonacci LFSR used to add random latency when MEM_JITTER_EN is defined.
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  // Shift register advancing once per enabled cycle, seeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], lfsr_feedback(q)};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-wide memory responder with configurable latency, preload port and protocol checking.
// Optional random extra latency is enabled by defining MEM_JITTER_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int JITTER_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_req,
  input  logic                         mem_we,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         mem_ready,
  output logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         ld_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  output logic                         ld_ack,
  output logic                         busy,
  output logic                         proto_err
);

  localparam int IW    = $clog2(MEM_DEPTH);
  // Wide enough for the largest load value LATENCY-1+JITTER_MAX.
  localparam int CNT_W = $clog2(LATENCY + JITTER_MAX + 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  mem_resp_state_t  state;
  mem_resp_state_t  state_next;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_load;

  logic                  we_r;
  logic [IW-1:0]         idx_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic          capture;
  logic [IW-1:0] req_idx;
  logic [IW-1:0] rd_idx;
  logic          rd_we;
  logic          enter_resp;
  logic          unused_addr;

  assign req_idx     = mem_addr[2 +: IW];
  assign capture     = (state == IDLE) && mem_req;
  assign rd_idx      = capture ? req_idx : idx_r;
  assign rd_we       = capture ? mem_we : we_r;
  assign enter_resp  = (state_next == RESP) && (state != RESP);
  assign ld_ack      = ld_we && (state == IDLE) && !mem_req;
  assign unused_addr = ^{mem_addr[1:0], mem_addr[ADDR_WIDTH-1:2+IW]};

`ifdef MEM_JITTER_EN
  logic [7:0] lfsr;

  mem_resp_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr % (JITTER_MAX + 1));
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // Next-state and latency-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = lat_cnt;
    case (state)
      IDLE: begin
        if (mem_req) begin
          cnt_next   = cnt_load;
          state_next = (cnt_load == {CNT_W{1'b0}}) ? RESP : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = lat_cnt - CNT_W'(1);
        if (lat_cnt <= CNT_W'(1)) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        // A request still held here belongs to the finishing transaction.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state, captured request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= {CNT_W{1'b0}};
      we_r      <= 1'b0;
      idx_r     <= {IW{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      mem_ready <= 1'b0;
      mem_rdata <= {DATA_WIDTH{1'b0}};
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      lat_cnt   <= cnt_next;
      mem_ready <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      if (capture) begin
        we_r    <= mem_we;
        idx_r   <= req_idx;
        wdata_r <= mem_wdata;
      end
      if (enter_resp && !rd_we) begin
        mem_rdata <= mem[rd_idx];
      end
      if (((state == WAIT) || (state == RESP)) && !mem_req) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Storage: writes commit when leaving RESP; preloads only land while idle.
  always_ff @(posedge clk) begin
    if ((state == RESP) && we_r) begin
      mem[idx_r] <= wdata_r;
    end else if (ld_ack) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus randomized traffic vs. a word-array model.
module tb_mem_responder;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 4096;
  localparam int IW  = 12;
  localparam int LAT = 4;
`ifdef MEM_JITTER_EN
  localparam int JM = 3;
`else
  localparam int JM = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          mem_req, mem_we, mem_ready, ld_we, ld_ack, busy, proto_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, ld_data;
  logic [IW-1:0] ld_addr;

  logic          mem_req1, mem_we1, mem_ready1, ld_we1, ld_ack1, busy1, proto_err1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_wdata1, mem_rdata1, ld_data1;
  logic [IW-1:0] ld_addr1;

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEP), .LATENCY(LAT), .JITTER_MAX(3)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .busy(busy), .proto_err(proto_err)
  );

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEP), .LATENCY(1), .JITTER_MAX(0)) u_lat1 (
    .clk(clk), .rst(rst), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_ready(mem_ready1), .mem_rdata(mem_rdata1), .ld_we(ld_we1),
    .ld_addr(ld_addr1), .ld_data(ld_data1), .ld_ack(ld_ack1), .busy(busy1), .proto_err(proto_err1)
  );

  logic [DW-1:0] model [DEP];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int k);
`ifdef MEM_JITTER_EN
    check(tag, 64'((k >= LAT) && (k <= LAT + JM)), 64'd1);
`else
    check(tag, 64'(k), 64'(LAT));
`endif
  endtask

  task automatic preload(input logic [IW-1:0] idx, input logic [DW-1:0] d);
    ld_we = 1'b1; ld_addr = idx; ld_data = d;
    #1;
    check("ld_ack_idle", 64'(ld_ack), 64'd1);
    @(posedge clk); #1;
    ld_we = 1'b0;
    model[idx] = d;
  endtask

  // Called in an idle cycle; leaves the bench in the following idle cycle with mem_req low.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                     input int drop_at, input string tag);
    int k;
    logic [IW-1:0] idx;
    idx = addr[2 +: IW];
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = d;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1 && !mem_ready) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (!mem_ready && k == drop_at) mem_req = 1'b0;
    end while (!mem_ready && k < 300);
    check({tag, "_ready"}, 64'(mem_ready), 64'd1);
    if (mem_ready) begin
      check_lat({tag, "_latency"}, k);
      if (!we) check({tag, "_rdata"}, 64'(mem_rdata), 64'(model[idx]));
      else model[idx] = d;
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(mem_ready), 64'd0);
    end
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  ri;
    logic        saw;
    rst = 1'b1;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    mem_req1 = 1'b0; mem_we1 = 1'b0; mem_addr1 = '0; mem_wdata1 = '0;
    ld_we1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(mem_ready), 64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_proto", 64'(proto_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) preload(IW'(i), $urandom());
    preload(12'd5, 32'hDEADBEEF);
    preload(12'h080, 32'hA5A5A5A5);

    txn(1'b0, 32'h14, 32'h0, 0, "rd_preload");
    check("rd_preload_val", 64'(mem_rdata), 64'hDEADBEEF);

    txn(1'b1, 32'h40, 32'h12345678, 0, "wr40");
    txn(1'b0, 32'h40, 32'h0, 0, "raw40");
    check("raw40_val", 64'(mem_rdata), 64'h12345678);

    txn(1'b1, 32'h100, 32'hCAFEF00D, 0, "wb");
    txn(1'b0, 32'h200, 32'h0, 0, "fill");
    check("fill_val", 64'(mem_rdata), 64'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("nodup_ready", 64'(mem_ready), 64'd0);
      check("nodup_busy", 64'(busy), 64'd0);
    end

    txn(1'b1, 32'h4000_0008, 32'h1, 0, "wrap_wr");
    txn(1'b0, 32'h8, 32'h0, 0, "wrap_rd");
    check("wrap_val", 64'(mem_rdata), 64'h1);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom();
      ri = 4'($urandom_range(0, 15));
      txn(1'($urandom_range(0, 1)), {r[31:14], 8'h00, ri, r[1:0]}, $urandom(), 0, "rand");
      if ($urandom_range(0, 3) == 0) preload(IW'($urandom_range(0, 15)), $urandom());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    check("proto_clean", 64'(proto_err), 64'd0);

    txn(1'b1, 32'h0C, 32'h0BADF00D, 2, "drop_wr");
    check("proto_set", 64'(proto_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("proto_sticky", 64'(proto_err), 64'd1);
    txn(1'b0, 32'h0C, 32'h0, 0, "drop_commit");
    check("drop_commit_val", 64'(mem_rdata), 64'h0BADF00D);

    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'h5555AAAA;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(mem_ready), 64'd0);
    check("midrst_rdata", 64'(mem_rdata), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_proto", 64'(proto_err), 64'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      saw = saw | mem_ready;
    end
    check("midrst_no_pulse", 64'(saw), 64'd0);
    txn(1'b0, 32'h10, 32'h0, 0, "midrst_nocommit");

    // LATENCY=1 instance: preload blocked while busy, accepted once idle.
    ld_we1 = 1'b1; ld_addr1 = 12'd0; ld_data1 = 32'h00001111;
    #1;
    check("l1_ld_ack0", 64'(ld_ack1), 64'd1);
    @(posedge clk); #1;
    mem_req1 = 1'b1; mem_we1 = 1'b0; mem_addr1 = 32'h0;
    ld_addr1 = 12'd7; ld_data1 = 32'hC0FFEE11;
    #1;
    check("l1_ld_nack_req", 64'(ld_ack1), 64'd0);
    @(posedge clk); #1;
    check("l1_ready", 64'(mem_ready1), 64'd1);
    check("l1_rdata", 64'(mem_rdata1), 64'h00001111);
    check("l1_busy", 64'(busy1), 64'd1);
    check("l1_ld_nack_busy", 64'(ld_ack1), 64'd0);
    @(posedge clk); #1;
    check("l1_pulse", 64'(mem_ready1), 64'd0);
    mem_req1 = 1'b0;
    #1;
    check("l1_ld_ack_idle", 64'(ld_ack1), 64'd1);
    @(posedge clk); #1;
    ld_we1 = 1'b0;
    mem_req1 = 1'b1; mem_addr1 = 32'h1C;
    @(posedge clk); #1;
    check("l1_ready2", 64'(mem_ready1), 64'd1);
    check("l1_rdata2", 64'(mem_rdata1), 64'hC0FFEE11);
    @(posedge clk); #1;
    mem_req1 = 1'b0;
    check("l1_pulse2", 64'(mem_ready1), 64'd0);
    check("l1_proto", 64'(proto_err1), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-wide memory responder that answers the data-cache miss/write-back interface (mem_req/mem_we/mem_addr/mem_wdata in, mem_ready/mem_rdata out).
- Sits below the dcache as its backing store for block-level simulation and FPGA bring-up.
- Models a configurable access latency and flags protocol violations from the initiator.
- Provides a side port for preloading contents.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.
- MEM_DEPTH, 4096, number of DATA_WIDTH words stored; power of two.
- LATENCY, 4, cycles from request capture to mem_ready; legal range 1..255.
- JITTER_MAX, 3, maximum extra random cycles; used only with MEM_JITTER_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mem_req  in  1  request; initiator holds high until mem_ready
- mem_we  in  1  1 = write, 0 = read; sampled at capture
- mem_addr  in  ADDR_WIDTH  byte address; sampled at capture
- mem_wdata  in  DATA_WIDTH  write data; sampled at capture
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_WIDTH  read data, valid while mem_ready=1 on reads
- ld_we  in  1  preload write strobe
- ld_addr  in  $clog2(MEM_DEPTH)  preload word index
- ld_data  in  DATA_WIDTH  preload data
- ld_ack  out  1  preload accepted this cycle (combinational)
- busy  out  1  high in WAIT or RESP
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-high.
- Reset values: state=IDLE, mem_ready=0, mem_rdata=0, busy=0, proto_err=0, lat_cnt=0.
- Array contents are not reset. They initialise to zero at time 0 in simulation.
- Word index = mem_addr[2 +: $clog2(MEM_DEPTH)]. Upper address bits are ignored, so accesses wrap modulo MEM_DEPTH. Low 2 bits are ignored.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - If mem_req=1, capture we/index/wdata and load lat_cnt=LATENCY-1.
  - Go to RESP if LATENCY=1, else go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt=1, go to RESP next cycle.
  - Timing rule: if the capture edge ends cycle T, mem_ready is high in cycle T+LATENCY.
- On the transition into RESP, a read registers mem_rdata = array[captured index].
- RESP: mem_ready=1 for exactly one cycle.
  - A write commits array[index] <= wdata on the edge that leaves RESP.
  - Next state is always IDLE.
  - The request still held high during the RESP cycle is not treated as new.
- Back-to-back: a request present in the IDLE cycle right after RESP is captured immediately. This is the write-back followed by fill sequence, and may use a new address.
- mem_rdata holds its last value outside RESP. Writes do not alter mem_rdata.
- Read-after-write to the same word, back-to-back, returns the new data.
- Protocol violation: mem_req=0 in any WAIT cycle, or in the RESP cycle, sets proto_err.
  - proto_err is cleared only by reset.
  - The transaction still completes: the ready pulse is issued and the write is committed.
- Preload port: ld_ack = ld_we && state==IDLE && !mem_req.
  - When acked, array[ld_addr] <= ld_data.
  - Otherwise ignored; the source retries.
- Reset mid-transaction: the transaction is dropped, no ready pulse is issued, and a pending write is not committed.

Optional Feature:
- Macro MEM_JITTER_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A on reset) advances every cycle.
  - At capture, extra = lfsr % (JITTER_MAX+1) is added, so lat_cnt = LATENCY-1+extra.
  - Latency lies in LATENCY..LATENCY+JITTER_MAX.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

Decomposition:
- Package mem_resp_pkg holds the state enum (mem_resp_state_t: IDLE, WAIT, RESP), the LFSR seed/taps constants, and the default LATENCY.
- One natural sub-module: mem_resp_lfsr (8-bit LFSR, enable, seed on reset), instantiated only under MEM_JITTER_EN.
- The storage array stays inline.

Test Plan:
- Preload word 5 = 32'hDEADBEEF. Read addr 32'h14 held until ready → mem_ready high exactly 4 cycles after capture, mem_rdata=32'hDEADBEEF, one-cycle pulse.
- Write addr 32'h40 data 32'h12345678. In the next IDLE cycle read 32'h40 → second ready 4 cycles after its capture, rdata=32'h12345678.
- Write-back then fill: write 0x100 then, on the cycle after ready, read 0x200 (preloaded 32'hA5A5A5A5) → both complete and rdata=32'hA5A5A5A5. No duplicate transaction on the held-req RESP cycle.
- Wrap: MEM_DEPTH=4096, write 0x4000_0008 = 32'h1 → read 0x8 returns 32'h1.
- Drop mem_req in WAIT → proto_err=1 and stays 1. Ready still pulses. Then assert rst mid-WAIT → no ready pulse, all outputs at reset values.
- LATENCY=1 with ld_we asserted during busy → ready the cycle after capture, ld_ack=0 while busy, and the preload is accepted once IDLE with mem_req=0.
